// File: rtl/cp0_reg.sv
// cp0_reg: MIPS-style coprocessor-0 register file.
// Holds Count, Compare, Status, Cause, EPC plus constant PRId/Config.
// It also handles the timer interrupt, exception entry and eret.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   we_i/waddr_i/data_i register write from MEM/WB
//   raddr_i / data_o    combinational register read (mfc0)
//   int_i               external interrupt lines, sampled into Cause[15:10]
//   excepttype_i        exception code from MEM (0 = none, 0x0E = eret)
//   current_inst_addr_i PC of the excepting instruction
//   is_in_delayslot_i   excepting instruction is in a delay slot
//   count_o..prid_o     current register values
//   timer_int_o         timer interrupt request
module cp0_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] PRID_VAL     = 32'h004C_0102;
    localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
    localparam logic [31:0] STATUS_RST   = 32'h1000_0000;

    localparam logic [31:0] EXC_INT      = 32'h01;
    localparam logic [31:0] EXC_SYSCALL  = 32'h08;
    localparam logic [31:0] EXC_RI       = 32'h0A;
    localparam logic [31:0] EXC_OV       = 32'h0C;
    localparam logic [31:0] EXC_TRAP     = 32'h0D;
    localparam logic [31:0] EXC_ERET     = 32'h0E;

    logic [31:0] r_count, r_compare, r_status, r_cause, r_epc;
    logic        r_timer_int;

    logic [31:0] w_count_nxt, w_compare_nxt, w_status_nxt, w_cause_nxt, w_epc_nxt;
    logic        w_timer_nxt;
    logic [4:0]  w_exccode;

    // Interrupt reports ExcCode 0; the other codes equal their excepttype value.
    assign w_exccode = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];

    always_comb begin
        w_count_nxt   = r_count + 32'd1;
        w_compare_nxt = r_compare;
        w_status_nxt  = r_status;
        w_cause_nxt   = r_cause;
        w_epc_nxt     = r_epc;
        w_timer_nxt   = r_timer_int;

        if ((r_compare != 32'd0) && (r_count == r_compare)) begin
            w_timer_nxt = 1'b1;
        end

        w_cause_nxt[15:10] = int_i;

        // Ordinary write first; exception handling below overrides it.
        if (we_i) begin
            case (waddr_i)
                ADDR_COUNT:   w_count_nxt = data_i;
                ADDR_COMPARE: begin
                    w_compare_nxt = data_i;
                    w_timer_nxt   = 1'b0;
                end
                ADDR_STATUS:  w_status_nxt = data_i;
                ADDR_CAUSE:   begin
                    w_cause_nxt[9:8]   = data_i[9:8];
                    w_cause_nxt[23:22] = data_i[23:22];
                end
                ADDR_EPC:     w_epc_nxt = data_i;
                default:      ;
            endcase
        end

        case (excepttype_i)
            EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP: begin
                // Nested exceptions keep the original return address and BD.
                if (!r_status[1]) begin
                    if (is_in_delayslot_i) begin
                        w_epc_nxt      = current_inst_addr_i - 32'd4;
                        w_cause_nxt[31] = 1'b1;
                    end else begin
                        w_epc_nxt      = current_inst_addr_i;
                        w_cause_nxt[31] = 1'b0;
                    end
                end
                w_status_nxt[1]  = 1'b1;
                w_cause_nxt[6:2] = w_exccode;
            end
            EXC_ERET: w_status_nxt[1] = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= 32'd0;
            r_compare   <= 32'd0;
            r_status    <= STATUS_RST;
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_timer_int <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_compare   <= w_compare_nxt;
            r_status    <= w_status_nxt;
            r_cause     <= w_cause_nxt;
            r_epc       <= w_epc_nxt;
            r_timer_int <= w_timer_nxt;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            ADDR_COUNT:   data_o = r_count;
            ADDR_COMPARE: data_o = r_compare;
            ADDR_STATUS:  data_o = r_status;
            ADDR_CAUSE:   data_o = r_cause;
            ADDR_EPC:     data_o = r_epc;
            ADDR_PRID:    data_o = PRID_VAL;
            ADDR_CONFIG:  data_o = CONFIG_VAL;
            default:      data_o = 32'd0;
        endcase
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign config_o    = CONFIG_VAL;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed table-driven bench for cp0_reg, plus hand-written
// sequences for timer, wrap, read-after-write and asynchronous reset.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int n_checks = 0;
    int n_errors = 0;

    cp0_reg dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  intr;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic [5:0] intr, input logic [31:0] exc,
                       input logic [31:0] pc, input logic ds, input logic [4:0] raddr,
                       input logic [31:0] exp);
        vec_t v;
        v.name = name; v.we = we; v.waddr = waddr; v.wdata = wdata; v.intr = intr;
        v.exc = exc; v.pc = pc; v.ds = ds; v.raddr = raddr; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; excepttype_i = 32'd0;
        current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},   count_o,   32'h0);
        check({tag, "_compare"}, compare_o, 32'h0);
        check({tag, "_status"},  status_o,  32'h1000_0000);
        check({tag, "_cause"},   cause_o,   32'h0);
        check({tag, "_epc"},     epc_o,     32'h0);
        check({tag, "_timer"},   {31'd0, timer_int_o}, 32'h0);
        check({tag, "_data_o"},  data_o,    32'h1000_0000);
    endtask

    initial begin
        bit          seen;
        logic [31:0] first_cnt;

        idle_inputs();
        int_i   = 6'd0;
        raddr_i = 5'd12;
        rst     = 1'b0;

        // name, we, waddr, wdata, int, exc, pc, ds, raddr, expected data_o
        add("wr_status",    1, 12, 32'h0000_FF01, 0,     32'h00, 32'h0,         0, 12, 32'h0000_FF01);
        add("wr_cause_all", 1, 13, 32'hFFFF_FFFF, 0,     32'h00, 32'h0,         0, 13, 32'h00C0_0300);
        add("cause_int",    1, 13, 32'h0,         6'h2A, 32'h00, 32'h0,         0, 13, 32'h0000_A800);
        add("wr_prid_ign",  1, 15, 32'h0,         0,     32'h00, 32'h0,         0, 15, 32'h004C_0102);
        add("wr_cfg_ign",   1, 16, 32'h0,         0,     32'h00, 32'h0,         0, 16, 32'h0000_8000);
        add("rd_unimpl",    1, 5,  32'h5555_5555, 0,     32'h00, 32'h0,         0, 5,  32'h0);
        add("wr_epc",       1, 14, 32'hDEAD_BEEF, 0,     32'h00, 32'h0,         0, 14, 32'hDEAD_BEEF);
        add("wr_count",     1, 9,  32'h1234_5678, 0,     32'h00, 32'h0,         0, 9,  32'h1234_5678);
        add("sys_ds_epc",   0, 0,  32'h0,         0,     32'h08, 32'h8000_0100, 1, 14, 32'h8000_00FC);
        add("sys_ds_cause", 0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 13, 32'h8000_0020);
        add("sys_status",   0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 12, 32'h0000_FF03);
        add("eret_status",  0, 0,  32'h0,         0,     32'h0E, 32'h0,         0, 12, 32'h0000_FF01);
        add("eret_epc",     0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 14, 32'h8000_00FC);
        add("int_epc",      0, 0,  32'h0,         0,     32'h01, 32'h8000_0200, 0, 14, 32'h8000_0200);
        add("int_cause",    0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 13, 32'h0);
        add("ov_exl_epc",   1, 14, 32'h0000_1234, 0,     32'h0C, 32'h8000_0400, 1, 14, 32'h0000_1234);
        add("ov_exl_cause", 0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 13, 32'h0000_0030);
        add("eret2",        0, 0,  32'h0,         0,     32'h0E, 32'h0,         0, 12, 32'h0000_FF01);
        add("bad_exc_epc",  0, 0,  32'h0,         0,     32'h05, 32'h0000_0999, 1, 14, 32'h0000_1234);
        add("bad_exc_caus", 0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 13, 32'h0000_0030);
        add("trap_wr_stat", 1, 12, 32'h0,         0,     32'h0D, 32'h8000_0300, 0, 12, 32'h0000_0002);
        add("trap_epc",     0, 0,  32'h0,         0,     32'h00, 32'h0,         0, 14, 32'h8000_0300);
        add("ri_exl_cause", 0, 0,  32'h0,         0,     32'h0A, 32'h0000_0004, 1, 13, 32'h0000_0028);
        add("trap_wr_caus", 1, 13, 32'h00C0_0300, 0,     32'h0D, 32'h0000_0008, 1, 13, 32'h00C0_0334);
        add("eret3",        0, 0,  32'h0,         0,     32'h0E, 32'h0,         0, 12, 32'h0);

        // Reset state
        #12;
        check_reset_values("rst");
        check("rst_prid",   prid_o,   32'h004C_0102);
        check("rst_config", config_o, 32'h0000_8000);

        // Release and idle 5 cycles
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle5_count",  count_o,  32'd5);
        check("idle5_status", status_o, 32'h1000_0000);
        check("idle5_prid",   prid_o,   32'h004C_0102);
        check("idle5_timer",  {31'd0, timer_int_o}, 32'h0);

        // Table
        foreach (vecs[i]) begin
            @(negedge clk);
            we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
            int_i = vecs[i].intr; excepttype_i = vecs[i].exc;
            current_inst_addr_i = vecs[i].pc; is_in_delayslot_i = vecs[i].ds;
            raddr_i = vecs[i].raddr;
            @(posedge clk);
            #1;
            idle_inputs();
            check(vecs[i].name, data_o, vecs[i].exp);
        end

        // Timer: Count=0x10, Compare=0x20
        @(negedge clk);
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h10;
        @(negedge clk);
        waddr_i = 5'd11; data_i = 32'h20;
        @(posedge clk);
        #1;
        idle_inputs();
        check("timer_low_after_cmp", {31'd0, timer_int_o}, 32'h0);
        seen = 1'b0;
        first_cnt = 32'h0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (timer_int_o) begin
                seen = 1'b1;
                first_cnt = count_o;
            end
        end
        check("timer_rise", {31'd0, seen}, 32'h1);
        check("timer_rise_count", first_cnt, 32'h21);
        repeat (10) @(posedge clk);
        #1;
        check("timer_hold", {31'd0, timer_int_o}, 32'h1);
        @(negedge clk);
        we_i = 1'b1; waddr_i = 5'd11; data_i = 32'h40;
        @(posedge clk);
        #1;
        idle_inputs();
        check("timer_clear", {31'd0, timer_int_o}, 32'h0);
        check("compare_val", compare_o, 32'h40);

        // Count wrap
        @(negedge clk);
        we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        idle_inputs();
        check("wrap_max", count_o, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("wrap_zero", count_o, 32'h0);

        // A write is not visible on data_o until after its edge
        @(negedge clk);
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'hCAFE_F00D; raddr_i = 5'd14;
        #1;
        check("no_bypass", data_o, 32'h8000_0300);
        @(posedge clk);
        #1;
        idle_inputs();
        check("after_write", data_o, 32'hCAFE_F00D);

        // Asynchronous reset mid-run, checked before the next edge
        raddr_i = 5'd12;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
